// File: rtl/cpu_icache_pkg.sv
// ============================================================================
// cpu_icache_pkg : shared FSM encodings and address-split width helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package cpu_icache_pkg;

   localparam logic [1:0] C_ST_IDLE = 2'b00;
   localparam logic [1:0] C_ST_FILL = 2'b01;
   localparam logic [1:0] C_ST_DONE = 2'b10;

   localparam int unsigned C_XLEN = 32;

   function automatic int unsigned off_w(input int unsigned wpl);
      return $clog2(wpl) + 2;
   endfunction

   function automatic int unsigned idx_w(input int unsigned lines);
      return $clog2(lines);
   endfunction

   function automatic int unsigned tag_w(input int unsigned lines, input int unsigned wpl);
      return C_XLEN - off_w(wpl) - idx_w(lines);
   endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_icache_if.sv
// ============================================================================
// cpu_icache_if : fetch-side and memory-bus signals of the instruction cache
// Rev 1.0
// ============================================================================
`default_nettype none

interface cpu_icache_if;
   logic [31:0] imem_addr;
   logic [31:0] iin;
   logic        icache_stall;
   logic        inv;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport slave (
      input  imem_addr, inv, mem_ack, mem_rdata,
      output iin, icache_stall, mem_req, mem_addr
   );

   modport master (
      output imem_addr, inv, mem_ack, mem_rdata,
      input  iin, icache_stall, mem_req, mem_addr
   );
endinterface

`default_nettype wire

// File: rtl/cpu_icache_fill_ctrl.sv
// ============================================================================
// cpu_icache_fill_ctrl : line-fill FSM, word counter, deferred invalidate, bus handshake
// Rev 1.0
// ============================================================================
`default_nettype none

module cpu_icache_fill_ctrl
   import cpu_icache_pkg::*;
#(
   parameter int unsigned LINES = 16,
   parameter int unsigned WPL   = 4
) (
   input  wire logic                          clk,
   input  wire logic                          rst,
   input  wire logic                          miss_i,
   input  wire logic                          inv_i,
   input  wire logic [C_XLEN-off_w(WPL)-1:0]  line_i,
   input  wire logic                          mem_ack_i,
   output logic                               idle_o,
   output logic                               mem_req_o,
   output logic [31:0]                        mem_addr_o,
   output logic                               word_we_o,
   output logic                               line_we_o,
   output logic                               inv_all_o,
   output logic [$clog2(WPL)-1:0]             cnt_o,
   output logic [C_XLEN-off_w(WPL)-1:0]       line_o
);

   localparam int unsigned WW   = $clog2(WPL);
   localparam int unsigned LW   = C_XLEN - off_w(WPL);
   localparam logic [WW-1:0] C_CNT_LAST = WW'(WPL - 1);

   logic [1:0]    state_q, state_d;
   logic [WW-1:0] cnt_q,   cnt_d;
   logic [LW-1:0] line_q,  line_d;
   logic          pend_q,  pend_d;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      line_d    = line_q;
      pend_d    = pend_q;
      word_we_o = 1'b0;
      line_we_o = 1'b0;
      inv_all_o = 1'b0;
      case (state_q)
         C_ST_IDLE: begin
            inv_all_o = inv_i;
            if (miss_i) begin
               state_d = C_ST_FILL;
               line_d  = line_i;
               cnt_d   = '0;
            end
         end
         C_ST_FILL: begin
            if (inv_i) pend_d = 1'b1;
            if (mem_ack_i) begin
               word_we_o = 1'b1;
               cnt_d     = cnt_q + 1'b1;
               if (cnt_q == C_CNT_LAST) begin
                  // An invalidate seen at any point of the fill also kills the new line.
                  if (pend_q || inv_i) inv_all_o = 1'b1;
                  else                 line_we_o = 1'b1;
                  pend_d  = 1'b0;
                  state_d = C_ST_DONE;
               end
            end
         end
         C_ST_DONE: begin
            inv_all_o = inv_i;
            state_d   = C_ST_IDLE;
         end
         default: state_d = C_ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= C_ST_IDLE;
         cnt_q   <= '0;
         line_q  <= '0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         line_q  <= line_d;
         pend_q  <= pend_d;
      end
   end

   assign idle_o     = (state_q == C_ST_IDLE);
   assign mem_req_o  = (state_q == C_ST_FILL);
   assign mem_addr_o = {line_q, cnt_q, 2'b00};
   assign cnt_o      = cnt_q;
   assign line_o     = line_q;

endmodule

`default_nettype wire

// File: rtl/cpu_icache.sv
// ============================================================================
// cpu_icache : direct-mapped read-only instruction cache, same-cycle hit path
// Rev 1.0
// ============================================================================
`default_nettype none

module cpu_icache
   import cpu_icache_pkg::*;
#(
   parameter int unsigned LINES = 16,
   parameter int unsigned WPL   = 4
) (
   input  wire logic   clk,
   input  wire logic   rst,
   cpu_icache_if.slave bus
);

   localparam int unsigned OFF = off_w(WPL);
   localparam int unsigned IDX = idx_w(LINES);
   localparam int unsigned TAG = tag_w(LINES, WPL);
   localparam int unsigned WW  = $clog2(WPL);
   localparam int unsigned LW  = TAG + IDX;

   logic [LINES-1:0] valid_q, valid_d;
   logic [TAG-1:0]   tag_ram_q [LINES];
   logic [31:0]      data_q    [LINES][WPL];

   logic [WW-1:0]  w_word;
   logic [IDX-1:0] w_idx;
   logic [TAG-1:0] w_tag;
   logic           w_match;
   logic           w_hit;
   logic           w_idle;
   logic           w_word_we;
   logic           w_line_we;
   logic           w_inv_all;
   logic [WW-1:0]  w_cnt;
   logic [LW-1:0]  w_fill_line;
   logic [IDX-1:0] w_fill_idx;
   logic [TAG-1:0] w_fill_tag;

   assign w_word  = bus.imem_addr[OFF-1:2];
   assign w_idx   = bus.imem_addr[OFF+IDX-1:OFF];
   assign w_tag   = bus.imem_addr[31:OFF+IDX];
   assign w_match = valid_q[w_idx] && (tag_ram_q[w_idx] == w_tag);
   assign w_hit   = w_match && w_idle;

   assign bus.iin          = w_hit ? data_q[w_idx][w_word] : 32'h0;
   assign bus.icache_stall = !w_hit;

   cpu_icache_fill_ctrl #(
      .LINES (LINES),
      .WPL   (WPL)
   ) u_fill_ctrl (
      .clk        (clk),
      .rst        (rst),
      .miss_i     (!w_match),
      .inv_i      (bus.inv),
      .line_i     (bus.imem_addr[31:OFF]),
      .mem_ack_i  (bus.mem_ack),
      .idle_o     (w_idle),
      .mem_req_o  (bus.mem_req),
      .mem_addr_o (bus.mem_addr),
      .word_we_o  (w_word_we),
      .line_we_o  (w_line_we),
      .inv_all_o  (w_inv_all),
      .cnt_o      (w_cnt),
      .line_o     (w_fill_line)
   );

   assign w_fill_idx = w_fill_line[IDX-1:0];
   assign w_fill_tag = w_fill_line[LW-1:IDX];

   // Invalidate takes priority so a fill that overlapped an inv leaves nothing valid.
   always_comb begin
      valid_d = valid_q;
      if (w_inv_all)      valid_d = '0;
      else if (w_line_we) valid_d[w_fill_idx] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) valid_q <= '0;
      else      valid_q <= valid_d;
   end

   always_ff @(posedge clk) begin
      if (w_line_we) tag_ram_q[w_fill_idx] <= w_fill_tag;
      if (w_word_we) data_q[w_fill_idx][w_cnt] <= bus.mem_rdata;
   end

endmodule

`default_nettype wire
